// File: rtl/reg_scoreboard_if.sv
// reg_scoreboard_if
//   Groups the decode-issue, writeback, flush and status signals of the
//   register scoreboard. The clock and reset are not part of it.
//   master : pipeline side (decode, writeback ports, PC/control). It drives the
//            d2sb_*, wb2sb_*, mul2sb_* and pc2sb_* signals and reads the
//            scoreboard status.
//   slave  : the scoreboard itself.
//   Signals
//     d2sb_issue/rd_num/rd_we/pred_we/long  instruction leaving decode
//     wb2sb_reg_valid/reg_num               ALU/LSU GPR writeback
//     wb2sb_pred_valid/pred_num             predicate writeback
//     mul2sb_valid/num                      MULT/DIV GPR writeback
//     pc2sb_flush                           squash non-long in-flight instrs
//     sb2d_reg_scoreboard/pred_scoreboard   pending-write masks to decode
//     sb2pc_idle/err                        idle indication, sticky error
interface reg_scoreboard_if #(
    parameter int NREGS  = 32,
    parameter int NPREDS = 3
);
    logic              d2sb_issue;
    logic [4:0]        d2sb_rd_num;
    logic              d2sb_rd_we;
    logic              d2sb_pred_we;
    logic              d2sb_long;
    logic              wb2sb_reg_valid;
    logic [4:0]        wb2sb_reg_num;
    logic              wb2sb_pred_valid;
    logic [1:0]        wb2sb_pred_num;
    logic              mul2sb_valid;
    logic [4:0]        mul2sb_num;
    logic              pc2sb_flush;
    logic [NREGS-1:0]  sb2d_reg_scoreboard;
    logic [NPREDS-1:0] sb2d_pred_scoreboard;
    logic              sb2pc_idle;
    logic              sb2pc_err;

    modport master (
        output d2sb_issue, d2sb_rd_num, d2sb_rd_we, d2sb_pred_we, d2sb_long,
        output wb2sb_reg_valid, wb2sb_reg_num, wb2sb_pred_valid, wb2sb_pred_num,
        output mul2sb_valid, mul2sb_num, pc2sb_flush,
        input  sb2d_reg_scoreboard, sb2d_pred_scoreboard, sb2pc_idle, sb2pc_err
    );

    modport slave (
        input  d2sb_issue, d2sb_rd_num, d2sb_rd_we, d2sb_pred_we, d2sb_long,
        input  wb2sb_reg_valid, wb2sb_reg_num, wb2sb_pred_valid, wb2sb_pred_num,
        input  mul2sb_valid, mul2sb_num, pc2sb_flush,
        output sb2d_reg_scoreboard, sb2d_pred_scoreboard, sb2pc_idle, sb2pc_err
    );
endinterface

// File: rtl/reg_scoreboard.sv
// reg_scoreboard
//   Tracks pending writes to the 32 GPRs and the 3 writable predicates (p3 is
//   always true and never tracked). Bits are set when an instruction issues and
//   cleared on writeback from the ALU/LSU or MULT/DIV port. A flush squashes
//   every pending write except the MULT/DIV ones.
//   Ports
//     clkrst_core_clk    core clock, all state updates on the rising edge
//     clkrst_core_rst_n  asynchronous active-low reset
//     sb                 reg_scoreboard_if.slave: issue, writeback, flush in;
//                        pending masks, idle and sticky error out
//   Build option
//     SB_BYPASS_EN  when defined, the decode masks drop bits that are being
//                   written back in the same cycle, so a consumer can issue on
//                   the writeback cycle. When undefined, the masks are the
//                   registered pending bits. State updates are identical.
module reg_scoreboard #(
    parameter int NREGS  = 32,
    parameter int NPREDS = 3
) (
    input logic             clkrst_core_clk,
    input logic             clkrst_core_rst_n,
    reg_scoreboard_if.slave sb
);
    logic [NREGS-1:0]  reg_pend;
    logic [NREGS-1:0]  long_mask;
    logic [NPREDS-1:0] pred_pend;
    logic              err;

    logic [NREGS-1:0]  reg_set;
    logic [NREGS-1:0]  long_set;
    logic [NREGS-1:0]  wb_clr;
    logic [NREGS-1:0]  mul_clr;
    logic [NREGS-1:0]  reg_clr;
    logic [NREGS-1:0]  keep_mask;
    logic [NPREDS-1:0] pred_set;
    logic [NPREDS-1:0] pred_clr;
    logic [3:0]        pred_pend_x;
    logic              issue_eff;
    logic              err_set;

    // An issue in the flush cycle belongs to a squashed instruction.
    assign issue_eff = sb.d2sb_issue & ~sb.pc2sb_flush;

    // p3 slot padded with 0 so a 2-bit predicate number can index it safely.
    assign pred_pend_x = {1'b0, pred_pend};

    always_comb begin
        reg_set  = '0;
        long_set = '0;
        pred_set = '0;
        wb_clr   = '0;
        mul_clr  = '0;
        pred_clr = '0;
        if (issue_eff && sb.d2sb_rd_we) begin
            reg_set[sb.d2sb_rd_num] = 1'b1;
            long_set[sb.d2sb_rd_num] = sb.d2sb_long;
        end
        // A GPR write takes priority; the predicate half of a dual write is dropped.
        if (issue_eff && sb.d2sb_pred_we && !sb.d2sb_rd_we && sb.d2sb_rd_num[1:0] != 2'd3)
            pred_set[sb.d2sb_rd_num[1:0]] = 1'b1;
        if (sb.wb2sb_reg_valid)
            wb_clr[sb.wb2sb_reg_num] = 1'b1;
        if (sb.mul2sb_valid)
            mul_clr[sb.mul2sb_num] = 1'b1;
        if (sb.wb2sb_pred_valid && sb.wb2sb_pred_num != 2'd3)
            pred_clr[sb.wb2sb_pred_num] = 1'b1;
    end

    assign reg_clr   = wb_clr | mul_clr;
    assign keep_mask = sb.pc2sb_flush ? long_mask : '1;

    always_comb begin
        err_set = 1'b0;
        if (issue_eff && sb.d2sb_rd_we && sb.d2sb_pred_we)
            err_set = 1'b1;
        if (issue_eff && sb.d2sb_rd_we && reg_pend[sb.d2sb_rd_num])
            err_set = 1'b1;
        if (issue_eff && sb.d2sb_pred_we && !sb.d2sb_rd_we && pred_pend_x[sb.d2sb_rd_num[1:0]])
            err_set = 1'b1;
        if (sb.wb2sb_reg_valid && !reg_pend[sb.wb2sb_reg_num])
            err_set = 1'b1;
        if (sb.mul2sb_valid && (!reg_pend[sb.mul2sb_num] || !long_mask[sb.mul2sb_num]))
            err_set = 1'b1;
        if (sb.wb2sb_pred_valid && sb.wb2sb_pred_num != 2'd3 && !pred_pend_x[sb.wb2sb_pred_num])
            err_set = 1'b1;
        if (sb.wb2sb_reg_valid && sb.mul2sb_valid && sb.wb2sb_reg_num == sb.mul2sb_num)
            err_set = 1'b1;
    end

    // Sets are applied after clears: a same-cycle clear belongs to an older write.
    always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
        if (!clkrst_core_rst_n) begin
            reg_pend  <= '0;
            long_mask <= '0;
            pred_pend <= '0;
            err       <= 1'b0;
        end else begin
            reg_pend  <= (reg_pend & keep_mask & ~reg_clr) | reg_set;
            long_mask <= (long_mask & ~mul_clr) | long_set;
            pred_pend <= sb.pc2sb_flush ? '0 : ((pred_pend & ~pred_clr) | pred_set);
            err       <= err | err_set;
        end
    end

`ifdef SB_BYPASS_EN
    assign sb.sb2d_reg_scoreboard  = reg_pend & ~reg_clr;
    assign sb.sb2d_pred_scoreboard = pred_pend & ~pred_clr;
`else
    assign sb.sb2d_reg_scoreboard  = reg_pend;
    assign sb.sb2d_pred_scoreboard = pred_pend;
`endif

    // long_mask bits are always a subset of reg_pend, so they need no term here.
    assign sb.sb2pc_idle = ~|reg_pend & ~|pred_pend;
    assign sb.sb2pc_err  = err;
endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;
    logic clk;
    logic rst_n;

    reg_scoreboard_if sb_if ();

    reg_scoreboard dut (
        .clkrst_core_clk   (clk),
        .clkrst_core_rst_n (rst_n),
        .sb                (sb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        do_rst;
        logic        issue;
        logic [4:0]  rd;
        logic        rd_we;
        logic        pred_we;
        logic        lng;
        logic        wb_v;
        logic [4:0]  wb_n;
        logic        wp_v;
        logic [1:0]  wp_n;
        logic        mul_v;
        logic [4:0]  mul_n;
        logic        flush;
        logic [31:0] e_reg;
        logic [2:0]  e_pred;
        logic        e_idle;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];
    int   n_checks;
    int   n_fail;

    function automatic vec_t mk(input int rst, input int iss, input int rd, input int rwe,
                                input int pwe, input int lng, input int wbv, input int wbn,
                                input int wpv, input int wpn, input int mv, input int mn,
                                input int fl, input logic [31:0] ereg, input int epred,
                                input int eidle, input int eerr);
        vec_t r;
        r.do_rst  = 1'(rst);
        r.issue   = 1'(iss);
        r.rd      = 5'(rd);
        r.rd_we   = 1'(rwe);
        r.pred_we = 1'(pwe);
        r.lng     = 1'(lng);
        r.wb_v    = 1'(wbv);
        r.wb_n    = 5'(wbn);
        r.wp_v    = 1'(wpv);
        r.wp_n    = 2'(wpn);
        r.mul_v   = 1'(mv);
        r.mul_n   = 5'(mn);
        r.flush   = 1'(fl);
        r.e_reg   = ereg;
        r.e_pred  = 3'(epred);
        r.e_idle  = 1'(eidle);
        r.e_err   = 1'(eerr);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] ereg, input logic [2:0] epred,
                           input logic eidle, input logic eerr);
        chk({tag, " reg_sb"}, sb_if.sb2d_reg_scoreboard, ereg);
        chk({tag, " pred_sb"}, 32'(sb_if.sb2d_pred_scoreboard), 32'(epred));
        chk({tag, " idle"}, 32'(sb_if.sb2pc_idle), 32'(eidle));
        chk({tag, " err"}, 32'(sb_if.sb2pc_err), 32'(eerr));
    endtask

    task automatic idle_inputs();
        sb_if.d2sb_issue       = 1'b0;
        sb_if.d2sb_rd_num      = '0;
        sb_if.d2sb_rd_we       = 1'b0;
        sb_if.d2sb_pred_we     = 1'b0;
        sb_if.d2sb_long        = 1'b0;
        sb_if.wb2sb_reg_valid  = 1'b0;
        sb_if.wb2sb_reg_num    = '0;
        sb_if.wb2sb_pred_valid = 1'b0;
        sb_if.wb2sb_pred_num   = '0;
        sb_if.mul2sb_valid     = 1'b0;
        sb_if.mul2sb_num       = '0;
        sb_if.pc2sb_flush      = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    // Drive one cycle of inputs on the falling edge, let the rising edge take
    // them, then return the inputs to idle so the outputs show the registered state.
    task automatic apply(input vec_t v);
        @(negedge clk);
        sb_if.d2sb_issue       = v.issue;
        sb_if.d2sb_rd_num      = v.rd;
        sb_if.d2sb_rd_we       = v.rd_we;
        sb_if.d2sb_pred_we     = v.pred_we;
        sb_if.d2sb_long        = v.lng;
        sb_if.wb2sb_reg_valid  = v.wb_v;
        sb_if.wb2sb_reg_num    = v.wb_n;
        sb_if.wb2sb_pred_valid = v.wp_v;
        sb_if.wb2sb_pred_num   = v.wp_n;
        sb_if.mul2sb_valid     = v.mul_v;
        sb_if.mul2sb_num       = v.mul_n;
        sb_if.pc2sb_flush      = v.flush;
        @(posedge clk);
        #1;
        idle_inputs();
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        idle_inputs();

        //                rst iss rd we pwe lng wbv wbn wpv wpn mv mn fl  e_reg         epred idle err
        vecs.push_back(mk(0, 1,  5, 1, 0, 0, 0,  0, 0, 0, 0,  0, 0, 32'h0000_0020, 0, 0, 0));
        vecs.push_back(mk(0, 0,  0, 0, 0, 0, 1,  5, 0, 0, 0,  0, 0, 32'h0000_0000, 0, 1, 0));
        vecs.push_back(mk(0, 1,  2, 0, 1, 0, 0,  0, 0, 0, 0,  0, 0, 32'h0000_0000, 4, 0, 0));
        vecs.push_back(mk(0, 1,  3, 0, 1, 0, 0,  0, 0, 0, 0,  0, 0, 32'h0000_0000, 4, 0, 0));
        vecs.push_back(mk(0, 0,  0, 0, 0, 0, 0,  0, 1, 2, 0,  0, 0, 32'h0000_0000, 0, 1, 0));
        vecs.push_back(mk(0, 1,  7, 1, 0, 1, 0,  0, 0, 0, 0,  0, 0, 32'h0000_0080, 0, 0, 0));
        vecs.push_back(mk(0, 1,  9, 1, 0, 0, 0,  0, 0, 0, 0,  0, 0, 32'h0000_0280, 0, 0, 0));
        vecs.push_back(mk(0, 1,  1, 0, 1, 0, 0,  0, 0, 0, 0,  0, 0, 32'h0000_0280, 2, 0, 0));
        vecs.push_back(mk(0, 1, 10, 1, 0, 0, 0,  0, 0, 0, 0,  0, 1, 32'h0000_0080, 0, 0, 0));
        vecs.push_back(mk(0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 1,  7, 0, 32'h0000_0000, 0, 1, 0));
        vecs.push_back(mk(0, 1,  1, 1, 0, 0, 0,  0, 0, 0, 0,  0, 0, 32'h0000_0002, 0, 0, 0));
        vecs.push_back(mk(0, 1,  2, 1, 0, 1, 1,  1, 0, 0, 0,  0, 0, 32'h0000_0004, 0, 0, 0));
        vecs.push_back(mk(0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 1, 32'h0000_0004, 0, 0, 0));
        vecs.push_back(mk(0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 1,  2, 0, 32'h0000_0000, 0, 1, 0));
        vecs.push_back(mk(0, 1, 31, 1, 0, 0, 0,  0, 0, 0, 0,  0, 0, 32'h8000_0000, 0, 0, 0));
        vecs.push_back(mk(0, 1,  0, 1, 0, 0, 0,  0, 0, 0, 0,  0, 0, 32'h8000_0001, 0, 0, 0));
        vecs.push_back(mk(0, 0,  0, 0, 0, 0, 1, 31, 0, 0, 0,  0, 0, 32'h0000_0001, 0, 0, 0));
        vecs.push_back(mk(0, 0,  0, 0, 0, 0, 1,  0, 0, 0, 0,  0, 0, 32'h0000_0000, 0, 1, 0));
        vecs.push_back(mk(0, 1,  4, 1, 0, 0, 0,  0, 0, 0, 0,  0, 0, 32'h0000_0010, 0, 0, 0));
        vecs.push_back(mk(0, 1,  4, 1, 0, 0, 1,  4, 0, 0, 0,  0, 0, 32'h0000_0010, 0, 0, 1));
        vecs.push_back(mk(0, 0,  0, 0, 0, 0, 1,  4, 0, 0, 0,  0, 0, 32'h0000_0000, 0, 1, 1));
        vecs.push_back(mk(1, 1,  1, 1, 1, 0, 0,  0, 0, 0, 0,  0, 0, 32'h0000_0002, 0, 0, 1));
        vecs.push_back(mk(1, 1,  8, 1, 0, 0, 0,  0, 0, 0, 0,  0, 0, 32'h0000_0100, 0, 0, 0));
        vecs.push_back(mk(0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 1,  8, 0, 32'h0000_0000, 0, 1, 1));
        vecs.push_back(mk(1, 1,  9, 1, 0, 1, 0,  0, 0, 0, 0,  0, 0, 32'h0000_0200, 0, 0, 0));
        vecs.push_back(mk(0, 0,  0, 0, 0, 0, 1,  9, 0, 0, 1,  9, 0, 32'h0000_0000, 0, 1, 1));
        vecs.push_back(mk(1, 0,  0, 0, 0, 0, 0,  0, 1, 3, 0,  0, 0, 32'h0000_0000, 0, 1, 0));
        vecs.push_back(mk(0, 0,  0, 0, 0, 0, 0,  0, 1, 0, 0,  0, 0, 32'h0000_0000, 0, 1, 1));
        vecs.push_back(mk(1, 1,  0, 0, 1, 0, 0,  0, 0, 0, 0,  0, 0, 32'h0000_0000, 1, 0, 0));
        vecs.push_back(mk(0, 1,  0, 0, 1, 0, 0,  0, 0, 0, 0,  0, 0, 32'h0000_0000, 1, 0, 1));
        vecs.push_back(mk(1, 0,  0, 0, 0, 0, 1, 12, 0, 0, 0,  0, 0, 32'h0000_0000, 0, 1, 1));
        vecs.push_back(mk(0, 1,  6, 1, 0, 0, 0,  0, 0, 0, 0,  0, 0, 32'h0000_0040, 0, 0, 1));
        vecs.push_back(mk(0, 0,  0, 0, 0, 0, 1,  6, 0, 0, 0,  0, 0, 32'h0000_0000, 0, 1, 1));

        #12;
        chk_all("reset", 32'h0, 3'b000, 1'b1, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].do_rst) do_reset();
            apply(vecs[i]);
            chk_all($sformatf("vec%0d", i), vecs[i].e_reg, vecs[i].e_pred,
                    vecs[i].e_idle, vecs[i].e_err);
        end

        // Asynchronous reset mid-cycle while a long write is pending and err is set.
        apply(mk(0, 1, 11, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0));
        chk_all("pre_async", 32'h0000_0800, 3'b000, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 32'h0, 3'b000, 1'b1, 1'b0);
        rst_n = 1'b1;
        // The squashed long write must not be remembered: its retirement is an error.
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 11, 0, 32'h0, 0, 0, 0));
        chk_all("mul_after_rst", 32'h0, 3'b000, 1'b1, 1'b1);

        // Same-cycle visibility of a writeback to decode.
        do_reset();
        apply(mk(0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0));
        @(negedge clk);
        sb_if.wb2sb_reg_valid = 1'b1;
        sb_if.wb2sb_reg_num   = 5'd3;
        #1;
`ifdef SB_BYPASS_EN
        chk("wb_cycle reg_sb", sb_if.sb2d_reg_scoreboard, 32'h0000_0000);
`else
        chk("wb_cycle reg_sb", sb_if.sb2d_reg_scoreboard, 32'h0000_0008);
`endif
        chk("wb_cycle idle", 32'(sb_if.sb2pc_idle), 32'd0);
        @(posedge clk);
        #1;
        idle_inputs();
        #1;
        chk_all("after_wb", 32'h0, 3'b000, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
